vx_issue_drain_scalar: RTL and testbench
========================================

VX_ISSUE_DRAIN_SCALAR -- requirements
Module: VX_issue_drain_scalar

Interface
REQ-001 SHALL have parameter THREAD_CNT, default `NUM_THREADS, threads per warp.
REQ-002 SHALL have parameter WARP_CNT, default `NUM_WARPS, warps per core.
REQ-003 SHALL have parameter ISSUE_CNT, default `MIN(WARP_CNT, 4), number of instruction-buffer slices drained.
REQ-004 SHALL derive localparams ISW_W = `LOG2UP(ISSUE_CNT), WIS_W = `LOG2UP(WARP_CNT/ISSUE_CNT), NW_W = `LOG2UP(WARP_CNT), and DATAW = `UUID_WIDTH + WIS_W + THREAD_CNT + `EX_BITS + `INST_OP_BITS + `INST_MOD_BITS + 3 + 2*`XLEN + 4*`NR_BITS.
REQ-005 SHALL have clk  input  1  rising-edge clock, the single clock domain.
REQ-006 SHALL have reset  input  1  synchronous, active-low reset (0 = in reset), sampled on the rising edge of clk.
REQ-007 SHALL have ibuf_valid  input  ISSUE_CNT  per-slice instruction-present flag.
REQ-008 SHALL have ibuf_ready  output  ISSUE_CNT  per-slice pop strobe; the slice is consumed when valid&&ready.
REQ-009 SHALL have ibuf_data  input  ISSUE_CNT x DATAW  per-slice packed record, MSB first: uuid, wis, tmask, ex_type, op_type, op_mod, wb, use_PC, use_imm, PC, imm, rd, rs1, rs2, rs3.
REQ-010 SHALL have dispatch_valid  output  1  dispatch register holds an instruction.
REQ-011 SHALL have dispatch_ready  input  1  downstream accepts the dispatch register.
REQ-012 SHALL have dispatch_wid  output  NW_W  full warp id of the dispatched instruction.
REQ-013 SHALL have dispatch_data  output  DATAW  the record exactly as popped from the slice.
REQ-014 SHALL have wb_valid  input  1  writeback-complete strobe.
REQ-015 SHALL have wb_wid  input  NW_W  warp id of the completing writeback.
REQ-016 SHALL have wb_rd  input  `NR_BITS  destination register being released.

Function
REQ-017 SHALL keep a pending table of WARP_CNT x 2^`NR_BITS bits; register index 0 is never set.
REQ-018 SHALL reconstruct the full warp id for slice i as {wis, i[ISW_W-1:0]}, where wis is taken from that slice's record.
REQ-019 SHALL mark slice i eligible when ibuf_valid[i] is 1 and none of rs1, rs2, rs3, or rd (rd only when wb=1) is pending for the reconstructed warp.
REQ-020 SHALL compute can_load = !dispatch_valid || dispatch_ready.
REQ-021 SHALL grant at most one eligible slice per cycle, and only when can_load is 1, selected round-robin starting at rr_ptr.
REQ-022 SHALL assert ibuf_ready[i] combinationally only for the granted slice; all other bits are 0.
REQ-023 SHALL, on a grant, load dispatch_data and dispatch_wid on the next edge and set dispatch_valid=1, giving 1 cycle latency from pop to dispatch.
REQ-024 SHALL, on a grant, set rr_ptr to granted index+1 modulo ISSUE_CNT; rr_ptr is unchanged when there is no grant.
REQ-025 SHALL, on a grant with wb=1 and rd!=0, set pending[wid][rd] on the same edge.
REQ-026 SHALL clear pending[wb_wid][wb_rd] on an edge where wb_valid=1.
REQ-027 SHALL let the set win when a set and a clear target the same bit in the same cycle.
REQ-028 SHALL clear dispatch_valid when dispatch_ready=1 and there is no grant; back-to-back dispatch with no bubble is required when a grant coincides with dispatch_ready=1.
REQ-029 SHALL hold dispatch_data and dispatch_wid stable while dispatch_valid=1 and dispatch_ready=0.
REQ-030 SHALL NOT use a writeback clear to forward into the eligibility decision of the same cycle; eligibility uses registered pending state only.

Reset
REQ-031 SHALL, while reset=0, clear dispatch_valid, rr_ptr, and every pending bit on the clock edge.
REQ-032 SHALL hold ibuf_ready=0 during reset, so no slice is popped.
REQ-033 SHALL discard any instruction held in the dispatch register when reset is asserted mid-operation, without dispatching it.
REQ-034 SHALL leave dispatch_data and dispatch_wid unreset; they are don't-care while dispatch_valid=0.

Verification
REQ-035 Bench SHALL cover: ISSUE_CNT=4, all slices valid with no hazards, dispatch_ready=1 -> grants in order 0,1,2,3,0, one per cycle, with dispatch_valid continuously 1.
REQ-036 Bench SHALL cover: slice 1 wis=1, wb=1, rd=5 dispatched, then slice 1 next record has rs2=5 -> dispatch_wid=5, slice 1 stalls; wb_valid with wb_wid=5, wb_rd=5 -> the record is dispatched 2 cycles after the wb pulse.
REQ-037 Bench SHALL cover: dispatch_ready held 0 for 3 cycles with dispatch_valid=1 -> dispatch_data stable, all ibuf_ready=0, and no pending bits change.
REQ-038 Bench SHALL cover: rd=0 with wb=1 -> pending[wid][0] stays 0, and a following instruction with rs1=0 dispatches without stall.
REQ-039 Bench SHALL cover: a grant setting pending[2][7] in the same cycle as wb_valid, wb_wid=2, wb_rd=7 -> the bit reads 1 afterward.
REQ-040 Bench SHALL cover: reset=0 pulsed while dispatch_valid=1 and pending bits are set -> next cycle dispatch_valid=0, the table is clear, rr_ptr=0, and the first grant after reset is slice 0.

Source files
------------

// File: rtl/vx_issue_drain_scalar.sv
// Issue-stage drain: picks one hazard-free instruction-buffer slice per cycle
// (round-robin) into a single dispatch register, tracking pending writes per warp.
`ifndef NUM_THREADS
  `define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
  `define NUM_WARPS 8
`endif
`ifndef UUID_WIDTH
  `define UUID_WIDTH 8
`endif
`ifndef EX_BITS
  `define EX_BITS 3
`endif
`ifndef INST_OP_BITS
  `define INST_OP_BITS 4
`endif
`ifndef INST_MOD_BITS
  `define INST_MOD_BITS 3
`endif
`ifndef XLEN
  `define XLEN 32
`endif
`ifndef NR_BITS
  `define NR_BITS 5
`endif
`ifndef LOG2UP
  `define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif
`ifndef MIN
  `define MIN(a, b) (((a) < (b)) ? (a) : (b))
`endif

module vx_issue_drain_scalar #(
  parameter int THREAD_CNT = `NUM_THREADS,
  parameter int WARP_CNT   = `NUM_WARPS,
  parameter int ISSUE_CNT  = `MIN(WARP_CNT, 4),
  localparam int ISW_W     = `LOG2UP(ISSUE_CNT),
  localparam int WIS_W     = `LOG2UP(WARP_CNT / ISSUE_CNT),
  localparam int NW_W      = `LOG2UP(WARP_CNT),
  localparam int DATAW     = `UUID_WIDTH + WIS_W + THREAD_CNT + `EX_BITS + `INST_OP_BITS
                             + `INST_MOD_BITS + 3 + 2 * `XLEN + 4 * `NR_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ISSUE_CNT-1:0]                ibuf_valid,
  output logic [ISSUE_CNT-1:0]                ibuf_ready,
  input  logic [ISSUE_CNT-1:0][DATAW-1:0]     ibuf_data,
  output logic                                dispatch_valid,
  input  logic                                dispatch_ready,
  output logic [NW_W-1:0]                     dispatch_wid,
  output logic [DATAW-1:0]                    dispatch_data,
  input  logic                                wb_valid,
  input  logic [NW_W-1:0]                     wb_wid,
  input  logic [`NR_BITS-1:0]                 wb_rd
);

  localparam int NR     = `NR_BITS;
  localparam int NREGS  = 1 << NR;
  localparam int RS3_LO = 0;
  localparam int RS2_LO = NR;
  localparam int RS1_LO = 2 * NR;
  localparam int RD_LO  = 3 * NR;
  localparam int WB_POS = 4 * NR + 2 * `XLEN + 2;
  localparam int WIS_LO = WB_POS + 1 + `INST_MOD_BITS + `INST_OP_BITS + `EX_BITS + THREAD_CNT;

  logic [WARP_CNT-1:0][NREGS-1:0] pending_q, pending_d;
  logic [ISW_W-1:0]               rr_q, rr_d;
  logic                           dv_q, dv_d;
  logic [DATAW-1:0]               data_q;
  logic [NW_W-1:0]                wid_q;

  logic [ISSUE_CNT-1:0]           elig;
  logic [ISSUE_CNT-1:0][NW_W-1:0] slice_wid;
  logic                           can_load;
  logic                           grant_valid;
  logic [ISW_W-1:0]               grant_idx;
  logic [DATAW-1:0]               g_rec;
  logic [NW_W-1:0]                g_wid;
  logic [NR-1:0]                  g_rd;
  logic                           g_wb;

  assign can_load = !dv_q || dispatch_ready;

  // Hazard check reads only the registered table; a same-cycle writeback is not forwarded.
  always_comb begin
    elig      = '0;
    slice_wid = '0;
    for (int unsigned i = 0; i < ISSUE_CNT; i++) begin
      logic [NR-1:0] rs1, rs2, rs3, rd;
      logic          wb;
      rs1 = ibuf_data[i][RS1_LO +: NR];
      rs2 = ibuf_data[i][RS2_LO +: NR];
      rs3 = ibuf_data[i][RS3_LO +: NR];
      rd  = ibuf_data[i][RD_LO +: NR];
      wb  = ibuf_data[i][WB_POS];
      slice_wid[i] = NW_W'({ibuf_data[i][WIS_LO +: WIS_W], ISW_W'(i)});
      elig[i] = ibuf_valid[i]
              && !pending_q[slice_wid[i]][rs1]
              && !pending_q[slice_wid[i]][rs2]
              && !pending_q[slice_wid[i]][rs3]
              && !(wb && pending_q[slice_wid[i]][rd]);
    end
  end

  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < ISSUE_CNT; k++) begin
      idx = (32'(rr_q) + k) % ISSUE_CNT;
      if (!grant_valid && elig[ISW_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = ISW_W'(idx);
      end
    end
    if (!(can_load && reset)) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    ibuf_ready = '0;
    for (int unsigned i = 0; i < ISSUE_CNT; i++) begin
      ibuf_ready[i] = grant_valid && (grant_idx == ISW_W'(i));
    end
  end

  assign g_rec = ibuf_data[grant_idx];
  assign g_wid = slice_wid[grant_idx];
  assign g_rd  = g_rec[RD_LO +: NR];
  assign g_wb  = g_rec[WB_POS];

  // Clear is applied first so a coincident set on the same bit wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) begin
      pending_d[wb_wid][wb_rd] = 1'b0;
    end
    if (grant_valid && g_wb && (g_rd != '0)) begin
      pending_d[g_wid][g_rd] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = (grant_idx == ISW_W'(ISSUE_CNT - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    dv_d = dv_q;
    if (grant_valid) begin
      dv_d = 1'b1;
    end else if (dispatch_ready) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dv_q      <= 1'b0;
      rr_q      <= '0;
      pending_q <= '0;
    end else begin
      dv_q      <= dv_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_valid) begin
      data_q <= g_rec;
      wid_q  <= g_wid;
    end
  end

  assign dispatch_valid = dv_q;
  assign dispatch_data  = data_q;
  assign dispatch_wid   = wid_q;

endmodule

// File: tb/tb_vx_issue_drain_scalar.sv
// Bench for vx_issue_drain_scalar: directed scenarios plus randomized traffic
// checked cycle-by-cycle against a behavioural issue/scoreboard model.
`ifndef NUM_THREADS
  `define NUM_THREADS 4
`endif
`ifndef UUID_WIDTH
  `define UUID_WIDTH 8
`endif
`ifndef EX_BITS
  `define EX_BITS 3
`endif
`ifndef INST_OP_BITS
  `define INST_OP_BITS 4
`endif
`ifndef INST_MOD_BITS
  `define INST_MOD_BITS 3
`endif
`ifndef XLEN
  `define XLEN 32
`endif
`ifndef NR_BITS
  `define NR_BITS 5
`endif

module tb_vx_issue_drain_scalar;
  localparam int THREADS = `NUM_THREADS;
  localparam int WARPS   = 8;
  localparam int ISSUE   = 4;
  localparam int NR      = `NR_BITS;
  localparam int WIS_W   = 1;
  localparam int NW_W    = 3;
  localparam int RS3_LO  = 0;
  localparam int RS2_LO  = NR;
  localparam int RS1_LO  = 2 * NR;
  localparam int RD_LO   = 3 * NR;
  localparam int WB_POS  = 4 * NR + 2 * `XLEN + 2;
  localparam int WIS_LO  = WB_POS + 1 + `INST_MOD_BITS + `INST_OP_BITS + `EX_BITS + THREADS;
  localparam int DATAW   = WIS_LO + WIS_W + `UUID_WIDTH;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [ISSUE-1:0]             ibuf_valid;
  logic [ISSUE-1:0]             ibuf_ready;
  logic [ISSUE-1:0][DATAW-1:0]  ibuf_data;
  logic                         dispatch_valid;
  logic                         dispatch_ready;
  logic [NW_W-1:0]              dispatch_wid;
  logic [DATAW-1:0]             dispatch_data;
  logic                         wb_valid;
  logic [NW_W-1:0]              wb_wid;
  logic [NR-1:0]                wb_rd;

  vx_issue_drain_scalar #(.THREAD_CNT(THREADS), .WARP_CNT(WARPS), .ISSUE_CNT(ISSUE)) dut (
    .clk(clk), .reset(rst_n),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_data(ibuf_data),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_wid(dispatch_wid), .dispatch_data(dispatch_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [WARPS-1:0][31:0] m_pend = '0;
  int                     m_rr   = 0;
  bit                     m_dv   = 1'b0;
  logic [DATAW-1:0]       m_data;
  int                     m_wid  = 0;
  logic [ISSUE-1:0]       obs_ready;
  logic [ISSUE-1:0]       exp_ready;

  function automatic int fld(input logic [DATAW-1:0] r, input int lo, input int w);
    return int'((r >> lo) & ((DATAW'(1) << w) - 1));
  endfunction

  function automatic logic [DATAW-1:0] mk(input int wis, input bit wb, input int rd,
                                          input int rs1, input int rs2, input int rs3);
    logic [DATAW-1:0] r;
    for (int b = 0; b < DATAW; b++) r[b] = 1'($urandom);
    r[RS3_LO +: NR]   = NR'(rs3);
    r[RS2_LO +: NR]   = NR'(rs2);
    r[RS1_LO +: NR]   = NR'(rs1);
    r[RD_LO +: NR]    = NR'(rd);
    r[WB_POS]         = wb;
    r[WIS_LO +: WIS_W] = WIS_W'(wis);
    return r;
  endfunction

  function automatic int rec_wid(input int slice);
    return fld(ibuf_data[slice], WIS_LO, WIS_W) * ISSUE + slice;
  endfunction

  function automatic bit m_eligible(input int s);
    logic [DATAW-1:0] r;
    int w;
    r = ibuf_data[s];
    w = rec_wid(s);
    if (!ibuf_valid[s]) return 1'b0;
    if (m_pend[w][fld(r, RS1_LO, NR)] || m_pend[w][fld(r, RS2_LO, NR)] ||
        m_pend[w][fld(r, RS3_LO, NR)]) return 1'b0;
    if (r[WB_POS] && m_pend[w][fld(r, RD_LO, NR)]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_grant();
    if (!rst_n) return -1;
    if (m_dv && !dispatch_ready) return -1;
    for (int k = 0; k < ISSUE; k++) begin
      if (m_eligible((m_rr + k) % ISSUE)) return (m_rr + k) % ISSUE;
    end
    return -1;
  endfunction

  function automatic void m_tick(input int g);
    logic [DATAW-1:0] r;
    if (!rst_n) begin
      m_dv = 1'b0; m_rr = 0; m_pend = '0;
      return;
    end
    if (wb_valid) m_pend[wb_wid][wb_rd] = 1'b0;
    if (g >= 0) begin
      r = ibuf_data[g];
      if (r[WB_POS] && fld(r, RD_LO, NR) != 0) m_pend[rec_wid(g)][fld(r, RD_LO, NR)] = 1'b1;
      m_dv = 1'b1; m_data = r; m_wid = rec_wid(g); m_rr = (g + 1) % ISSUE;
    end else if (dispatch_ready) begin
      m_dv = 1'b0;
    end
  endfunction

  // Called at posedge+1; samples the pop strobe at the falling edge, then advances the model.
  task automatic cycle();
    int g;
    #4;
    obs_ready = ibuf_ready;
    g = m_grant();
    exp_ready = (g >= 0) ? ISSUE'(1) << g : '0;
    @(posedge clk);
    m_tick(g);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ibuf_valid = '1; dispatch_ready = 1'b1; wb_valid = 1'b0;
    for (int i = 0; i < ISSUE; i++) ibuf_data[i] = mk(0, 0, 1, 1, 2, 3);
    repeat (2) begin
      cycle();
      n_cmp++; if (obs_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
      n_cmp++; if (dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b want 0", dispatch_valid); end
    end
    n_cmp++; if (dut.pending_q !== '0) begin n_bad++; $display("FAIL reset_pending: got %h want 0", dut.pending_q); end
    rst_n = 1'b1; ibuf_valid = '0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < ISSUE; i++) ibuf_data[i] = mk($urandom_range(0, 1), 0, 4, 1, 2, 3);
    ibuf_valid = '1; dispatch_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cmp++; if (obs_ready !== ISSUE'(1) << (k % ISSUE)) begin n_bad++; $display("FAIL rr_order[%0d]: got %b want slice %0d", k, obs_ready, k % ISSUE); end
      n_cmp++; if (dispatch_valid !== 1'b1) begin n_bad++; $display("FAIL rr_dv[%0d]: got %b want 1", k, dispatch_valid); end
      n_cmp++; if (dispatch_wid !== NW_W'(rec_wid(k % ISSUE))) begin n_bad++; $display("FAIL rr_wid[%0d]: got %0d want %0d", k, dispatch_wid, rec_wid(k % ISSUE)); end
      n_cmp++; if (dispatch_data !== ibuf_data[k % ISSUE]) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, dispatch_data, ibuf_data[k % ISSUE]); end
    end
    ibuf_valid = '0;
  endtask

  task automatic test_raw_hazard();
    logic [DATAW-1:0] rec_b;
    ibuf_valid = 4'b0010; dispatch_ready = 1'b1;
    ibuf_data[1] = mk(1, 1, 5, 1, 2, 3);
    cycle();
    n_cmp++; if (obs_ready !== 4'b0010) begin n_bad++; $display("FAIL raw_first_grant: got %b want 0010", obs_ready); end
    n_cmp++; if (dispatch_wid !== 3'd5) begin n_bad++; $display("FAIL raw_wid: got %0d want 5", dispatch_wid); end
    rec_b = mk(1, 0, 0, 1, 5, 3);
    ibuf_data[1] = rec_b;
    repeat (2) begin
      cycle();
      n_cmp++; if (obs_ready !== '0) begin n_bad++; $display("FAIL raw_stall: got %b want 0000", obs_ready); end
    end
    n_cmp++; if (dut.pending_q[5][5] !== 1'b1) begin n_bad++; $display("FAIL raw_pending: got %b want 1", dut.pending_q[5][5]); end
    wb_valid = 1'b1; wb_wid = 3'd5; wb_rd = 5'd5;
    cycle();
    n_cmp++; if (obs_ready !== '0) begin n_bad++; $display("FAIL raw_no_forward: got %b want 0000", obs_ready); end
    wb_valid = 1'b0;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0010) begin n_bad++; $display("FAIL raw_release: got %b want 0010", obs_ready); end
    n_cmp++; if (dispatch_valid !== 1'b1 || dispatch_data !== rec_b) begin n_bad++; $display("FAIL raw_dispatch: got v=%b %h want v=1 %h", dispatch_valid, dispatch_data, rec_b); end
    ibuf_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [DATAW-1:0] held;
    ibuf_valid = 4'b1000; dispatch_ready = 1'b1;
    held = mk(1, 1, 9, 1, 2, 3);
    ibuf_data[3] = held;
    cycle();
    n_cmp++; if (obs_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_load: got %b want 1000", obs_ready); end
    dispatch_ready = 1'b0; ibuf_valid = '1;
    for (int i = 0; i < ISSUE; i++) ibuf_data[i] = mk(0, 1, 10 + i, 1, 2, 3);
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_cmp++; if (obs_ready !== '0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, obs_ready); end
      n_cmp++; if (dispatch_valid !== 1'b1 || dispatch_data !== held) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", c, dispatch_valid, dispatch_data, held); end
      n_cmp++; if (dispatch_wid !== 3'd7) begin n_bad++; $display("FAIL bp_wid[%0d]: got %0d want 7", c, dispatch_wid); end
      n_cmp++; if (dut.pending_q !== m_pend) begin n_bad++; $display("FAIL bp_pending[%0d]: got %h want %h", c, dut.pending_q, m_pend); end
    end
    dispatch_ready = 1'b1; ibuf_valid = '0;
    cycle();
    n_cmp++; if (dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", dispatch_valid); end
    wb_valid = 1'b1; wb_wid = 3'd7; wb_rd = 5'd9;
    cycle();
    wb_valid = 1'b0;
    n_cmp++; if (dut.pending_q !== m_pend) begin n_bad++; $display("FAIL bp_clear: got %h want %h", dut.pending_q, m_pend); end
  endtask

  task automatic test_rd_zero();
    ibuf_valid = 4'b0001; dispatch_ready = 1'b1;
    ibuf_data[0] = mk(0, 1, 0, 1, 2, 3);
    cycle();
    n_cmp++; if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL rd0_grant: got %b want 0001", obs_ready); end
    n_cmp++; if (dut.pending_q[0][0] !== 1'b0) begin n_bad++; $display("FAIL rd0_bit: got %b want 0", dut.pending_q[0][0]); end
    ibuf_data[0] = mk(0, 0, 0, 0, 0, 0);
    cycle();
    n_cmp++; if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL rd0_no_stall: got %b want 0001", obs_ready); end
    ibuf_valid = '0;
  endtask

  task automatic test_set_clear_same();
    ibuf_valid = 4'b0100; dispatch_ready = 1'b1;
    ibuf_data[2] = mk(0, 1, 7, 1, 2, 3);
    wb_valid = 1'b1; wb_wid = 3'd2; wb_rd = 5'd7;
    cycle();
    wb_valid = 1'b0;
    n_cmp++; if (obs_ready !== 4'b0100) begin n_bad++; $display("FAIL setclr_grant: got %b want 0100", obs_ready); end
    n_cmp++; if (dut.pending_q[2][7] !== 1'b1) begin n_bad++; $display("FAIL setclr_bit: got %b want 1", dut.pending_q[2][7]); end
    ibuf_data[2] = mk(0, 0, 0, 7, 1, 1);
    cycle();
    n_cmp++; if (obs_ready !== '0) begin n_bad++; $display("FAIL setclr_stall: got %b want 0000", obs_ready); end
    ibuf_valid = '0; wb_valid = 1'b1;
    cycle();
    wb_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ibuf_valid = ISSUE'($urandom);
      for (int i = 0; i < ISSUE; i++)
        ibuf_data[i] = mk($urandom_range(0, 1), 1'($urandom), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      dispatch_ready = ($urandom_range(0, 3) != 0);
      wb_valid = 1'($urandom); wb_wid = NW_W'($urandom); wb_rd = NR'($urandom_range(0, 7));
      cycle();
      n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, obs_ready, exp_ready); end
      n_cmp++; if (dispatch_valid !== m_dv) begin n_bad++; $display("FAIL rnd_dv[%0d]: got %b want %b", c, dispatch_valid, m_dv); end
      if (m_dv) begin
        n_cmp++; if (dispatch_data !== m_data || dispatch_wid !== NW_W'(m_wid)) begin n_bad++; $display("FAIL rnd_disp[%0d]: got %0d/%h want %0d/%h", c, dispatch_wid, dispatch_data, m_wid, m_data); end
      end
      n_cmp++; if (dut.pending_q !== m_pend) begin n_bad++; $display("FAIL rnd_pending[%0d]: got %h want %h", c, dut.pending_q, m_pend); end
    end
    ibuf_valid = '0; dispatch_ready = 1'b1; wb_valid = 1'b1;
    for (int w = 0; w < WARPS; w++) begin
      for (int r = 0; r < 8; r++) begin
        wb_wid = NW_W'(w); wb_rd = NR'(r);
        cycle();
      end
    end
    wb_valid = 1'b0;
    n_cmp++; if (dut.pending_q !== '0) begin n_bad++; $display("FAIL rnd_drain: got %h want 0", dut.pending_q); end
  endtask

  task automatic test_mid_reset();
    logic [DATAW-1:0] first;
    ibuf_valid = 4'b0001; dispatch_ready = 1'b1;
    ibuf_data[0] = mk(0, 1, 3, 1, 2, 4);
    cycle();
    dispatch_ready = 1'b0; ibuf_valid = '0;
    cycle();
    n_cmp++; if (dispatch_valid !== 1'b1 || dut.pending_q[0][3] !== 1'b1) begin n_bad++; $display("FAIL mrst_setup: got v=%b p=%b want 1/1", dispatch_valid, dut.pending_q[0][3]); end
    rst_n = 1'b0; ibuf_valid = '1;
    for (int i = 0; i < ISSUE; i++) ibuf_data[i] = mk(0, 0, 0, 1, 2, 3);
    cycle();
    rst_n = 1'b1;
    n_cmp++; if (obs_ready !== '0) begin n_bad++; $display("FAIL mrst_ready: got %b want 0000", obs_ready); end
    n_cmp++; if (dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_dv: got %b want 0", dispatch_valid); end
    n_cmp++; if (dut.pending_q !== '0) begin n_bad++; $display("FAIL mrst_pending: got %h want 0", dut.pending_q); end
    first = ibuf_data[0];
    dispatch_ready = 1'b1;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0001) begin n_bad++; $display("FAIL mrst_first_slice: got %b want 0001", obs_ready); end
    n_cmp++; if (dispatch_valid !== 1'b1 || dispatch_data !== first) begin n_bad++; $display("FAIL mrst_dispatch: got v=%b %h want v=1 %h", dispatch_valid, dispatch_data, first); end
    ibuf_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; ibuf_valid = '0; ibuf_data = '0; dispatch_ready = 1'b0;
    wb_valid = 1'b0; wb_wid = '0; wb_rd = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_raw_hazard();
    test_backpressure();
    test_rd_zero();
    test_set_clear_same();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
